// File: rtl/alu_operand_sequencer_if.sv
// Pin-side bundle for the ALU operand sequencer: switches and raw buttons in,
// latched operands, select and status out.
interface alu_operand_sequencer_if;
  logic [7:0] sw;
  logic       btn_next;
  logic       btn_back;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [3:0] sel;
  logic       valid;
  logic [1:0] step;
  logic       err;

  modport slave (
    input  sw, btn_next, btn_back,
    output op_a, op_b, sel, valid, step, err
  );

  modport master (
    output sw, btn_next, btn_back,
    input  op_a, op_b, sel, valid, step, err
  );
endinterface

// File: rtl/alu_operand_sequencer.sv
// Walks the user through entering operand A, operand B and an ALU select code
// from slide switches, using two debounced pushbuttons to step forward/back.
module alu_operand_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SEL         = 12
) (
  input  logic                    clk,
  input  logic                    rst,
  alu_operand_sequencer_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0]        SEL_MAX  = 4'(MAX_SEL);

  typedef enum logic [1:0] {
    LOAD_A  = 2'd0,
    LOAD_B  = 2'd1,
    LOAD_OP = 2'd2,
    RUN     = 2'd3
  } step_e;

  logic [1:0] raw_btn;
  logic [1:0] press_evt;
  logic [1:0] fill_q;
  logic       settled;

  assign raw_btn = {bus.btn_back, bus.btn_next};

  // Counts the two cycles the synchronizers need to refill after reset, so a
  // button already held at reset release is seen before it can arm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q <= 2'd0;
    end else if (fill_q != 2'd2) begin
      fill_q <= fill_q + 2'd1;
    end
  end

  assign settled = (fill_q == 2'd2);

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic             meta_q;
    logic             sync_q;
    logic             deb_q;
    logic             arm_q;
    logic             press_q;
    logic [CNT_W-1:0] cnt_q;

    // A press only counts once the button has been seen released after
    // reset; a press registered here reaches the FSM on the following edge.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        meta_q  <= 1'b0;
        sync_q  <= 1'b0;
        deb_q   <= 1'b0;
        arm_q   <= 1'b0;
        press_q <= 1'b0;
        cnt_q   <= '0;
      end else begin
        meta_q  <= raw_btn[i];
        sync_q  <= meta_q;
        press_q <= 1'b0;
        if (settled && !sync_q) begin
          arm_q <= 1'b1;
        end
        if (sync_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_q   <= '0;
          deb_q   <= sync_q;
          press_q <= sync_q & arm_q;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign press_evt[i] = press_q;
  end

  logic       next_evt;
  logic       back_evt;
  step_e      state_q;
  logic [7:0] op_a_q;
  logic [7:0] op_b_q;
  logic [3:0] sel_q;
  logic       valid_q;
  logic       err_q;

  // Simultaneous next and back cancel each other out.
  assign next_evt = press_evt[0] & ~press_evt[1];
  assign back_evt = press_evt[1] & ~press_evt[0];

  // valid is high exactly while the FSM sits in RUN; op_a/op_b/sel are then
  // stable and the ALU result mux may consume sel. There is no ready: the ALU
  // simply follows whatever is presented.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD_A;
      op_a_q  <= 8'd0;
      op_b_q  <= 8'd0;
      sel_q   <= 4'd0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (next_evt) begin
        unique case (state_q)
          LOAD_A: begin
            op_a_q  <= bus.sw;
            state_q <= LOAD_B;
          end
          LOAD_B: begin
            op_b_q  <= bus.sw;
            state_q <= LOAD_OP;
          end
          LOAD_OP: begin
            if (bus.sw[3:0] <= SEL_MAX) begin
              sel_q   <= bus.sw[3:0];
              state_q <= RUN;
              valid_q <= 1'b1;
            end else begin
              err_q <= 1'b1;
            end
          end
          RUN: begin
            state_q <= LOAD_A;
            valid_q <= 1'b0;
          end
          default: state_q <= LOAD_A;
        endcase
      end else if (back_evt) begin
        unique case (state_q)
          LOAD_A:  state_q <= LOAD_A;
          LOAD_B:  state_q <= LOAD_A;
          LOAD_OP: state_q <= LOAD_B;
          RUN: begin
            state_q <= LOAD_OP;
            valid_q <= 1'b0;
          end
          default: state_q <= LOAD_A;
        endcase
      end
    end
  end

  assign bus.op_a  = op_a_q;
  assign bus.op_b  = op_b_q;
  assign bus.sel   = sel_q;
  assign bus.valid = valid_q;
  assign bus.step  = state_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized scoreboard bench for alu_operand_sequencer with a step-level
// reference model and latency-window checks on every output update.
module tb_alu_operand_sequencer;
  localparam int N    = 4;
  localparam int MAXS = 12;
  localparam int W    = 24;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  int   cyc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_operand_sequencer_if bus ();

  alu_operand_sequencer #(
    .DEBOUNCE_CYCLES(N),
    .MAX_SEL(MAXS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // ---------------- scoreboard ----------------
  int total;
  int bad;
  logic [W-1:0] exp_q[$];
  int           exp_t_q[$];

  int         m_step;
  logic [7:0] m_a;
  logic [7:0] m_b;
  logic [3:0] m_sel;

  function automatic logic [W-1:0] pack(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] s, input int st, input logic e);
    logic v;
    v = (st == 3);
    return {a, b, s, v, 2'(st), e};
  endfunction

  function automatic logic [W-1:0] dut_tuple();
    return {bus.op_a, bus.op_b, bus.sel, bus.valid, bus.step, bus.err};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string name);
    check(name, dut_tuple(), pack(m_a, m_b, m_sel, m_step, 1'b0));
  endtask

  // Reference model: one step per accepted press.
  task automatic model_apply(input bit dn, input bit db, input logic [7:0] swv, input int t);
    if (dn && !db) begin
      if (m_step == 0) begin
        m_a = swv; m_step = 1;
        exp_q.push_back(pack(m_a, m_b, m_sel, m_step, 1'b0));
      end else if (m_step == 1) begin
        m_b = swv; m_step = 2;
        exp_q.push_back(pack(m_a, m_b, m_sel, m_step, 1'b0));
      end else if (m_step == 2) begin
        if (int'(swv[3:0]) <= MAXS) begin
          m_sel = swv[3:0]; m_step = 3;
          exp_q.push_back(pack(m_a, m_b, m_sel, m_step, 1'b0));
        end else begin
          exp_q.push_back(pack(m_a, m_b, m_sel, m_step, 1'b1));
        end
      end else begin
        m_step = 0;
        exp_q.push_back(pack(m_a, m_b, m_sel, m_step, 1'b0));
      end
      exp_t_q.push_back(t);
    end else if (db && !dn && m_step > 0) begin
      m_step = m_step - 1;
      exp_q.push_back(pack(m_a, m_b, m_sel, m_step, 1'b0));
      exp_t_q.push_back(t);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [W-1:0] cur;
    logic [W-1:0] prev;
    logic [W-1:0] e;
    int           t;
    prev = '0;
    forever begin
      @(negedge clk);
      cur = dut_tuple();
      if (rst !== 1'b0) begin
        prev = cur;
      end else begin
        if (cur[W-1:1] !== prev[W-1:1] || cur[0] !== 1'b0) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_update: got %h want no change from %h (t=%0t)", cur, prev, $time);
          end else begin
            e = exp_q.pop_front();
            t = exp_t_q.pop_front();
            check("update", cur, e);
            total++;
            if (cyc < t + N + 2 || cyc > t + N + 4) begin
              bad++;
              $display("FAIL latency: got cycle %0d want %0d..%0d", cyc, t + N + 2, t + N + 4);
            end
          end
        end
        prev = cur;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic settle();
    repeat (N + 10) @(posedge clk);
    #1;
    bus.sw = 8'($urandom);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL timeout: got %0d pending updates want 0", exp_q.size());
      exp_q.delete();
      exp_t_q.delete();
    end
  endtask

  task automatic press(input bit dn, input bit db, input logic [7:0] swv, input int hold);
    @(posedge clk); #1;
    bus.sw       = swv;
    bus.btn_next = dn;
    bus.btn_back = db;
    model_apply(dn, db, swv, cyc + 1);
    repeat (hold) @(posedge clk);
    #1;
    bus.btn_next = 1'b0;
    bus.btn_back = 1'b0;
    settle();
  endtask

  task automatic bounce_next(input logic [7:0] swv);
    int lens[3];
    lens = '{1, 2, 3};
    @(posedge clk); #1;
    bus.sw = swv;
    for (int i = 0; i < 3; i++) begin
      bus.btn_next = 1'b1;
      repeat (lens[i]) @(posedge clk);
      #1;
      bus.btn_next = 1'b0;
      @(posedge clk); #1;
    end
    bus.btn_next = 1'b1;
    model_apply(1'b1, 1'b0, swv, cyc + 1);
    repeat (100) @(posedge clk);
    #1;
    bus.btn_next = 1'b0;
    settle();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: got no end of test want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int         k;
    int         hold;
    logic [7:0] s;
    total = 0;
    bad   = 0;
    m_step = 0; m_a = 8'd0; m_b = 8'd0; m_sel = 4'd0;
    bus.sw = 8'd0;
    bus.btn_next = 1'b0;
    bus.btn_back = 1'b0;
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_outputs", dut_tuple(), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);

    // Basic entry
    press(1, 0, 8'h3C, 10);
    press(1, 0, 8'h05, 10);
    press(1, 0, 8'h00, 10);
    check("basic_run", dut_tuple(), pack(8'h3C, 8'h05, 4'h0, 3, 1'b0));

    // Bounce then long hold: exactly one advance (RUN -> LOAD_A)
    bounce_next(8'h77);
    check_state("after_bounce");

    // Illegal select handling, prior sel=2
    press(1, 0, 8'h5A, 9);
    press(1, 0, 8'hA5, 9);
    press(1, 0, 8'h02, 9);
    press(0, 1, 8'h00, 9);
    check_state("in_load_op_sel2");
    press(1, 0, 8'h0D, 9);
    check_state("illegal_kept");
    press(1, 0, 8'hFC, 9);
    check("upper_nibble_ignored", dut_tuple(), pack(8'h5A, 8'hA5, 4'hC, 3, 1'b0));

    // Back navigation 3->2->1->0->0
    for (int i = 0; i < 4; i++) begin
      press(0, 1, 8'($urandom), 9);
      check_state("back_nav");
    end

    // Simultaneous press in LOAD_B
    press(1, 0, 8'h19, 9);
    press(1, 1, 8'hEE, 12);
    check_state("simultaneous");

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      k    = $urandom_range(0, 19);
      s    = 8'($urandom);
      hold = $urandom_range(8, 30);
      if (m_step == 2 && $urandom_range(0, 1) == 1) s[3:0] = 4'($urandom_range(12, 15));
      if (k < 12)      press(1, 0, s, hold);
      else if (k < 17) press(0, 1, s, hold);
      else             press(1, 1, s, hold);
    end
    check_state("random_end");

    // Reset during a partially counted press in LOAD_OP
    while (m_step != 0) press(0, 1, 8'h00, 9);
    press(1, 0, 8'hAA, 9);
    press(1, 0, 8'h33, 9);
    check_state("pre_reset_load_op");
    @(posedge clk); #1;
    bus.sw = 8'h07;
    bus.btn_next = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("reset_async", dut_tuple(), '0);
    m_step = 0; m_a = 8'd0; m_b = 8'd0; m_sel = 4'd0;
    exp_q.delete();
    exp_t_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    bus.btn_next = 1'b0;
    settle();
    check_state("held_through_reset");
    press(1, 0, 8'h11, 9);
    check("press_after_reset", dut_tuple(), pack(8'h11, 8'h00, 4'h0, 1, 1'b0));

    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
